// File: rtl/lap_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lap_timer_pkg
//  Description : Shared BCD constants, clamp helper and count-direction enum
//                for the lap_timer stopwatch core.
//  Revision    : 1.0 - initial release
// ============================================================================
package lap_timer_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } mode_t;

  // Force an out-of-range BCD nibble (A..F) down to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lap_timer_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_cell
//  Description : Combinational single BCD digit step. Increments (dir=UP) or
//                decrements (dir=DOWN) when enabled and flags carry/borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cell
  import lap_timer_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [BCD_W-1:0] d_o,
  output logic             co_o
);

  // Step the digit; carry/borrow out only when the digit wraps.
  always_comb begin
    d_o  = d_i;
    co_o = 1'b0;
    if (en_i) begin
      if (dir_i == DOWN) begin
        if (d_i == '0) begin
          d_o  = BCD_MAX;
          co_o = 1'b1;
        end else begin
          d_o = d_i - 4'd1;
        end
      end else begin
        if (d_i >= BCD_MAX) begin
          d_o  = '0;
          co_o = 1'b1;
        end else begin
          d_o = d_i + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lap_timer
//  Description : Parametrised BCD stopwatch/countdown core with preset load
//                and a circular lap memory with indexed recall.
//  Revision    : 1.0 - initial release
// ============================================================================
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int LAP_DEPTH  = 7,
  parameter int IW         = $clog2(LAP_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_i,
  input  logic                        start_stop_i,
  input  logic                        clear_i,
  input  logic                        mode_i,
  input  logic                        load_i,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val_i,
  input  logic                        lap_i,
  input  logic [IW-1:0]               rd_idx_i,
  output logic [BCD_W*NUM_DIGITS-1:0] digits_o,
  output logic                        running_o,
  output logic                        mode_q_o,
  output logic [BCD_W*NUM_DIGITS-1:0] lap_dout_o,
  output logic [IW:0]                 lap_count_o,
  output logic                        wrap_o,
  output logic                        done_o
);

  localparam int DW = BCD_W * NUM_DIGITS;
  localparam int CW = IW + 1;
  localparam int AW = IW + 2;

  logic [DW-1:0] digits_q,   digits_d;
  logic          running_q,  running_d;
  logic          mode_lat_q, mode_d;
  logic          wrap_q,     wrap_d;
  logic          done_q,     done_d;
  logic [IW-1:0] wptr_q,     wptr_d;
  logic [CW-1:0] lap_count_q, lap_count_d;
  logic [DW-1:0] lap_dout_q, lap_dout_d;
  logic [DW-1:0] laps_q [LAP_DEPTH];

  logic [NUM_DIGITS:0] chain;
  logic [DW-1:0]       step_val;
  logic                lap_we;
  logic [AW-1:0]       rd_sum;
  logic [AW-1:0]       rd_pos;
  logic                rd_hit;

  // Ripple chain: digit 0 always steps, higher digits step on carry/borrow.
  assign chain[0] = 1'b1;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .d_i   (digits_q[g*BCD_W +: BCD_W]),
        .en_i  (chain[g]),
        .dir_i (mode_lat_q),
        .d_o   (step_val[g*BCD_W +: BCD_W]),
        .co_o  (chain[g+1])
      );
    end
  endgenerate

  // Counter control: clear > load > start_stop > tick.
  always_comb begin
    digits_d  = digits_q;
    running_d = running_q;
    wrap_d    = 1'b0;
    done_d    = 1'b0;
    // mode tracks the input whenever stopped, so a start uses the mode being latched
    mode_d    = running_q ? mode_lat_q : mode_i;
    if (clear_i) begin
      digits_d  = '0;
      running_d = 1'b0;
    end else if (load_i && !running_q) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_d[i*BCD_W +: BCD_W] = bcd_clamp(load_val_i[i*BCD_W +: BCD_W]);
      end
    end else if (start_stop_i) begin
      if (running_q) begin
        running_d = 1'b0;
      end else if (!(mode_d == DOWN && digits_q == '0)) begin
        running_d = 1'b1;
      end
    end else if (tick_i && running_q) begin
      digits_d = step_val;
      if (mode_lat_q == UP) begin
        wrap_d = chain[NUM_DIGITS];
      end else if (step_val == '0) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  // Lap write pointer/occupancy and the registered recall path.
  always_comb begin
    lap_we      = lap_i && !clear_i;
    wptr_d      = wptr_q;
    lap_count_d = lap_count_q;
    if (clear_i) begin
      wptr_d      = '0;
      lap_count_d = '0;
    end else if (lap_we) begin
      wptr_d = (wptr_q == IW'(LAP_DEPTH - 1)) ? '0 : wptr_q + IW'(1);
      if (lap_count_q != CW'(LAP_DEPTH)) begin
        lap_count_d = lap_count_q + CW'(1);
      end
    end
    // entry (wptr-1-rd_idx) mod LAP_DEPTH; only meaningful when rd_idx < lap_count
    rd_sum = {2'b00, wptr_q} + AW'(LAP_DEPTH - 1) - {2'b00, rd_idx_i};
    rd_pos = (rd_sum >= AW'(LAP_DEPTH)) ? rd_sum - AW'(LAP_DEPTH) : rd_sum;
    rd_hit = ({1'b0, rd_idx_i} < lap_count_q);
    lap_dout_d = rd_hit ? laps_q[rd_pos[IW-1:0]] : '0;
  end

  // State registers, including lap storage, cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q    <= '0;
      running_q   <= 1'b0;
      mode_lat_q  <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      wptr_q      <= '0;
      lap_count_q <= '0;
      lap_dout_q  <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        laps_q[i] <= '0;
      end
    end else begin
      digits_q    <= digits_d;
      running_q   <= running_d;
      mode_lat_q  <= mode_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      wptr_q      <= wptr_d;
      lap_count_q <= lap_count_d;
      lap_dout_q  <= lap_dout_d;
      if (lap_we) begin
        laps_q[wptr_q] <= digits_q;
      end
    end
  end

  assign digits_o    = digits_q;
  assign running_o   = running_q;
  assign mode_q_o    = mode_lat_q;
  assign lap_dout_o  = lap_dout_q;
  assign lap_count_o = lap_count_q;
  assign wrap_o      = wrap_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lap_timer
//  Description : Directed self-checking bench for lap_timer (4 digits, 7 laps).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_timer;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        tick_i;
  logic        start_stop_i;
  logic        clear_i;
  logic        mode_i;
  logic        load_i;
  logic [15:0] load_val_i;
  logic        lap_i;
  logic [2:0]  rd_idx_i;
  logic [15:0] digits_o;
  logic        running_o;
  logic        mode_q_o;
  logic [15:0] lap_dout_o;
  logic [3:0]  lap_count_o;
  logic        wrap_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic wrap_seen;

  lap_timer #(
    .NUM_DIGITS (4),
    .LAP_DEPTH  (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (tick_i),
    .start_stop_i (start_stop_i),
    .clear_i      (clear_i),
    .mode_i       (mode_i),
    .load_i       (load_i),
    .load_val_i   (load_val_i),
    .lap_i        (lap_i),
    .rd_idx_i     (rd_idx_i),
    .digits_o     (digits_o),
    .running_o    (running_o),
    .mode_q_o     (mode_q_o),
    .lap_dout_o   (lap_dout_o),
    .lap_count_o  (lap_count_o),
    .wrap_o       (wrap_o),
    .done_o       (done_o)
  );

  // Gated clock so the async reset can be applied with the clock frozen.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk_en = 1'b1; rst = 1'b1;
    tick_i = 0; start_stop_i = 0; clear_i = 0; mode_i = 0;
    load_i = 0; load_val_i = '0; lap_i = 0; rd_idx_i = '0;
    wrap_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_digits", digits_o, 32'h0);
    chk("rst_running", running_o, 0);
    chk("rst_lap_count", lap_count_o, 0);
    chk("rst_lap_dout", lap_dout_o, 0);
    chk("rst_wrap_done", {wrap_o, done_o}, 0);

    // start and 12 up ticks
    start_stop_i = 1; cyc(); start_stop_i = 0;
    chk("start_running", running_o, 1);
    tick_i = 1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (wrap_o) wrap_seen = 1'b1;
    end
    tick_i = 0;
    chk("up12_digits", digits_o, 32'h0012);
    chk("up12_running", running_o, 1);
    chk("up12_no_wrap", wrap_seen, 0);

    // stop, preset 9998, roll over
    start_stop_i = 1; cyc(); start_stop_i = 0;
    chk("stop_running", running_o, 0);
    load_val_i = 16'h9998; load_i = 1; cyc(); load_i = 0;
    chk("load_9998", digits_o, 32'h9998);
    start_stop_i = 1; cyc(); start_stop_i = 0;
    tick_i = 1;
    cyc(); chk("roll_9999", {wrap_o, digits_o}, 32'h0_9999);
    cyc(); chk("roll_0000", {wrap_o, digits_o}, 32'h1_0000);
    chk("roll_running", running_o, 1);
    cyc(); chk("roll_0001", {wrap_o, digits_o}, 32'h0_0001);
    tick_i = 0;

    // load ignored while running
    load_val_i = 16'h1234; load_i = 1; cyc(); load_i = 0;
    chk("load_while_run", digits_o, 32'h0001);
    start_stop_i = 1; cyc(); start_stop_i = 0;

    // per-digit clamp of the preset
    load_val_i = 16'hA0F5; load_i = 1; cyc(); load_i = 0;
    chk("load_clamp", digits_o, 32'h9095);

    // countdown 0003 -> 0000
    mode_i = 1; load_val_i = 16'h0003; load_i = 1; cyc(); load_i = 0;
    chk("mode_latched", mode_q_o, 1);
    start_stop_i = 1; cyc(); start_stop_i = 0;
    tick_i = 1;
    cyc(); chk("down_0002", {running_o, done_o, digits_o}, 32'h2_0002);
    cyc(); chk("down_0001", {running_o, done_o, digits_o}, 32'h2_0001);
    cyc(); chk("down_0000", {running_o, done_o, wrap_o, digits_o}, 32'h2_0000);
    tick_i = 0;
    cyc(); chk("done_pulse_end", done_o, 0);
    start_stop_i = 1; cyc(); start_stop_i = 0;
    chk("start_at_zero", {running_o, done_o}, 0);

    // mode frozen while running
    load_val_i = 16'h0005; load_i = 1; cyc(); load_i = 0;
    start_stop_i = 1; cyc(); start_stop_i = 0;
    mode_i = 0; cyc();
    chk("mode_frozen", mode_q_o, 1);
    start_stop_i = 1; cyc(); start_stop_i = 0;
    cyc();
    chk("mode_relatched", mode_q_o, 0);
    clear_i = 1; cyc(); clear_i = 0;
    chk("clear_digits", digits_o, 32'h0);

    // laps at counts 5..12 (one more than depth)
    start_stop_i = 1; cyc(); start_stop_i = 0;
    tick_i = 1;
    repeat (5) cyc();
    lap_i = 1;
    cyc();
    chk("lap_count_1", lap_count_o, 1);
    repeat (7) cyc();
    lap_i = 0; tick_i = 0;
    chk("lap_count_sat", lap_count_o, 7);
    rd_idx_i = 0; cyc();
    chk("lap_rd0", lap_dout_o, 32'h0012);
    chk("lap_digits", digits_o, 32'h0013);
    rd_idx_i = 1; cyc();
    chk("lap_rd1", lap_dout_o, 32'h0011);
    rd_idx_i = 6; cyc();
    chk("lap_rd6", lap_dout_o, 32'h0006);

    // lap and tick in the same cycle
    start_stop_i = 1; cyc(); start_stop_i = 0;
    load_val_i = 16'h0041; load_i = 1; cyc(); load_i = 0;
    start_stop_i = 1; cyc(); start_stop_i = 0;
    lap_i = 1; tick_i = 1; cyc(); lap_i = 0; tick_i = 0;
    chk("laptick_digits", digits_o, 32'h0042);
    rd_idx_i = 0; cyc();
    chk("laptick_stored", lap_dout_o, 32'h0041);
    chk("laptick_count", lap_count_o, 7);

    // clear wins over lap and tick
    clear_i = 1; lap_i = 1; tick_i = 1; cyc();
    clear_i = 0; lap_i = 0; tick_i = 0;
    chk("clr_combo", {running_o, lap_count_o, digits_o}, 32'h0);
    cyc();
    chk("clr_lap_dout", lap_dout_o, 0);

    // async reset with the clock frozen mid-count
    mode_i = 1; load_val_i = 16'h0050; load_i = 1; cyc(); load_i = 0;
    start_stop_i = 1; cyc(); start_stop_i = 0;
    tick_i = 1; repeat (2) cyc(); tick_i = 0;
    lap_i = 1; cyc(); lap_i = 0;
    rd_idx_i = 0; cyc();
    chk("pre_rst_lap", lap_dout_o, 32'h0048);
    chk("pre_rst_digits", digits_o, 32'h0048);
    clk_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_digits", digits_o, 0);
    chk("arst_flags", {running_o, mode_q_o, wrap_o, done_o}, 0);
    chk("arst_laps", {lap_count_o, lap_dout_o}, 0);
    mode_i = 0;
    #2 rst = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_idx_i = 3'(i);
      cyc();
      chk("post_rst_lap", lap_dout_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lap_timer.md
Name: lap_timer

Overview:
- Parametrised stopwatch/countdown core for the stopwatch top level.
- Counts NUM_DIGITS BCD digits on an external tick strobe. Supports up and down modes, preset load, and a circular lap memory of LAP_DEPTH entries with indexed recall.
- Sits between the debounced button pulses and the seg7/display path.
- Replaces the fixed 4-digit counter and the tied-off lap slots.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8).
- LAP_DEPTH, 7, number of lap entries stored (2..16).
- IW, $clog2(LAP_DEPTH), width of the lap read index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle count strobe (1 count unit).
- start_stop  in  1  one-cycle pulse; toggles running.
- clear  in  1  one-cycle pulse; zero the counter and empty the lap memory.
- mode  in  1  0 = count up, 1 = count down; latched only while stopped.
- load  in  1  one-cycle pulse; preset the counter from load_val (only while stopped).
- load_val  in  4*NUM_DIGITS  BCD preset; digit 0 in bits [3:0].
- lap  in  1  one-cycle pulse; capture the current count.
- rd_idx  in  IW  lap select; 0 = most recent lap.
- digits  out  4*NUM_DIGITS  current BCD count.
- running  out  1  counter active.
- mode_q  out  1  latched mode.
- lap_dout  out  4*NUM_DIGITS  selected lap value.
- lap_count  out  IW+1  stored laps, saturates at LAP_DEPTH.
- wrap  out  1  one-cycle pulse on up-mode rollover.
- done  out  1  one-cycle pulse on reaching zero in down mode.

Behaviour:
- Reset (async, rst=1): digits=0, running=0, mode_q=0, lap_count=0, lap_dout=0, wrap=0, done=0, write pointer=0, lap storage=0.
- All outputs are registered.
  - An accepted event on edge N is visible after edge N.
  - lap_dout has 1-cycle latency from rd_idx/lap_count.
- Priority when events coincide in one cycle: clear > load > start_stop > tick.
  - lap is independent of this chain (see lap rules below).
- clear: digits=0, running=0, lap_count=0, write pointer=0. mode_q is kept. A lap in the same cycle is dropped.
- load:
  - Accepted only when running=0; ignored while running.
  - Each digit of load_val that is >9 is clamped to 9.
- mode_q <= mode on every cycle with running=0. Frozen while running.
- start_stop:
  - Stopped -> running=1, except in down mode with digits==0, where it stays stopped and done is not pulsed.
  - Running -> running=0. A tick in the same cycle is ignored.
- tick with running=1, up mode:
  - BCD increment; digit 9 -> 0 carries to the next digit.
  - All 9s -> all 0s: wrap=1 for that cycle, running stays 1.
- tick with running=1, down mode:
  - BCD decrement; digit 0 -> 9 borrows from the next digit.
  - Transition to all 0s: running=0 and done=1 in the same cycle the zero value appears.
- tick with running=0: no effect.
- lap:
  - Accepted regardless of running.
  - Stores the pre-update value of digits, i.e. the value before any tick/load in that same cycle.
  - Storage is written at the write pointer; the pointer increments modulo LAP_DEPTH.
  - lap_count increments and saturates at LAP_DEPTH. When full, the oldest entry is overwritten.
- Recall:
  - lap_dout = entry (wptr-1-rd_idx) mod LAP_DEPTH.
  - If rd_idx >= lap_count, lap_dout = 0.
- wrap and done are never high in the same cycle.

Decomposition:
- Package lap_timer_pkg:
  - BCD_W=4 and BCD_MAX=4'd9.
  - Function bcd_clamp.
  - Enum mode_t {UP=0, DOWN=1}.
- Sub-module bcd_digit_cell: a combinational single digit.
  - Inputs: d, en, dir.
  - Outputs: next d, carry/borrow out.
  - Instantiated NUM_DIGITS times in a ripple chain.
- Lap memory is a register array inside lap_timer. No RAM macro.

Test Plan:
- Reset then start_stop, 12 ticks, up mode, NUM_DIGITS=4 -> digits=0012, running=1, wrap never high.
- load 9998, start_stop, 3 ticks -> digits 9999, 0000 (wrap=1 for exactly that cycle), 0001; running stays 1.
- mode=1, load 0003, start_stop, 3 ticks -> 0002, 0001, 0000 with done=1 and running=0 on the third; a further start_stop leaves running=0 and done=0.
- Laps at counts 5, 6, ... 12 (8 laps, LAP_DEPTH=7) -> lap_count=7; rd_idx=0 gives 0012 one cycle later; rd_idx=6 gives 0006 (0005 overwritten).
- Same-cycle events:
  - lap+tick at 0041 -> stored lap 0041, digits 0042.
  - clear+lap+tick -> digits 0, lap_count 0.
  - load while running -> ignored.
- rst asserted mid-count asynchronously with clk stopped -> all outputs 0 immediately; lap_dout for any rd_idx = 0 after release.
